// File: rtl/quant_pkg.sv
// Shared types and constants for the JPEG quantization-table sequencer.
// Holds the FSM state encoding, table layout and float exponent field bounds.
package quant_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    LATCH = 3'd3,
    OUT   = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam int N_COEF      = 64;
  localparam int LUMA_BASE   = 0;
  localparam int CHROMA_BASE = 64;
  localparam int FP_EXP_MSB  = 30;
  localparam int FP_EXP_LSB  = 23;

  // Zero or denormal quantizers cannot be used as a divisor.
  function automatic logic exp_is_zero(input logic [31:0] w);
    return (w[FP_EXP_MSB:FP_EXP_LSB] == 8'd0);
  endfunction

endpackage

// File: rtl/quant_sequencer.sv
// Walks one 8x8 block through the quantization-table ROM and hands
// {coefficient, quantizer} pairs to the float divider over valid/ready.
module quant_sequencer
  import quant_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              chroma_i,
  input  logic              coef_valid_i,
  input  logic [DATA_W-1:0] coef_data_i,
  output logic              coef_ready_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              q_valid_o,
  input  logic              q_ready_i,
  output logic [DATA_W-1:0] q_coef_o,
  output logic [DATA_W-1:0] q_div_o,
  output logic [5:0]        q_idx_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [5:0] IDX_LAST = 6'(N_COEF - 1);

  state_e            state_q, state_d;
  logic [5:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] coef_q, coef_d;
  logic [DATA_W-1:0] div_q, div_d;
  logic              err_q, err_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    base_d     = base_q;
    rom_addr_d = rom_addr_q;
    coef_d     = coef_q;
    div_d      = div_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d  = chroma_i ? ADDR_W'(CHROMA_BASE) : ADDR_W'(LUMA_BASE);
          idx_d   = 6'd0;
          err_d   = 1'b0;
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (coef_valid_i) begin
          coef_d     = coef_data_i;
          rom_addr_d = base_q + ADDR_W'(idx_q);
          state_d    = WAIT;
        end else begin
          state_d = FETCH;
        end
      end
      // ROM registers rom_addr_o at the end of this cycle.
      WAIT: state_d = LATCH;
      LATCH: begin
        div_d   = rom_data_i;
        err_d   = err_q | exp_is_zero(rom_data_i);
        state_d = OUT;
      end
      OUT: begin
        if (q_ready_i) begin
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = FETCH;
          end
        end else begin
          state_d = OUT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      idx_q      <= 6'd0;
      base_q     <= ADDR_W'(LUMA_BASE);
      rom_addr_q <= '0;
      coef_q     <= '0;
      div_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      base_q     <= base_d;
      rom_addr_q <= rom_addr_d;
      coef_q     <= coef_d;
      div_q      <= div_d;
      err_q      <= err_d;
    end
  end

  assign coef_ready_o = (state_q == FETCH);
  assign q_valid_o    = (state_q == OUT);
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign rom_addr_o   = rom_addr_q;
  assign q_coef_o     = coef_q;
  assign q_div_o      = div_q;
  assign q_idx_o      = idx_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_quant_sequencer.sv
// Bench for quant_sequencer: a table of block scenarios driven with random
// upstream/downstream handshakes and scored against a behavioural ROM model.
module tb_quant_sequencer;

  logic        clk;
  logic        rst_ni;
  logic        start_i;
  logic        chroma_i;
  logic        coef_valid_i;
  logic [31:0] coef_data_i;
  logic        coef_ready_o;
  logic [12:0] rom_addr_o;
  logic [31:0] rom_data;
  logic        q_valid_o;
  logic        q_ready_i;
  logic [31:0] q_coef_o;
  logic [31:0] q_div_o;
  logic [5:0]  q_idx_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int n_checks = 0;
  int n_pass   = 0;

  quant_sequencer dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .chroma_i    (chroma_i),
    .coef_valid_i(coef_valid_i),
    .coef_data_i (coef_data_i),
    .coef_ready_o(coef_ready_o),
    .rom_addr_o  (rom_addr_o),
    .rom_data_i  (rom_data),
    .q_valid_o   (q_valid_o),
    .q_ready_i   (q_ready_i),
    .q_coef_o    (q_coef_o),
    .q_div_o     (q_div_o),
    .q_idx_o     (q_idx_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Standard JPEG luma/chroma quantization tables, raster order.
  int luma_tab [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,   12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,   14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77, 24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101, 72, 92, 95, 98, 112, 100, 103, 99};
  int chroma_tab [64] = '{
    17, 18, 24, 47, 99, 99, 99, 99,   18, 21, 26, 66, 99, 99, 99, 99,
    24, 26, 56, 99, 99, 99, 99, 99,   47, 66, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,   99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,   99, 99, 99, 99, 99, 99, 99, 99};

  logic [31:0] rom_mem [128];

  always @(posedge clk) begin
    rom_data <= (rom_addr_o < 13'd128) ? rom_mem[rom_addr_o[6:0]] : 32'h0;
  end

  function automatic logic [31:0] int_to_fp(input int v);
    int          p;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    p = 0;
    for (int b = 0; b < 24; b++) if (v >= (1 << b)) p = b;
    m = 32'(v) << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic        chroma;
    int          gap;
    int          hold;
    int          stall_idx;
    int          zero_idx;
    int          restart_idx;
    int          abort_idx;
    logic        start_at_done;
    int          exp_done_cyc;
    logic [31:0] exp_div0;
    logic [31:0] exp_div63;
    logic        exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input int row, input vec_t v);
    int          base, k, n, cyc, done_cnt, done_cyc, last_acc, stall_cnt;
    logic        err_m, held, pulsed, c_acc, vnew, rnew;
    logic [31:0] coefs [64];
    logic [31:0] h_coef, h_div, saved;
    logic [5:0]  h_idx;
    base = v.chroma ? 64 : 0;
    for (int i = 0; i < 64; i++) coefs[i] = $urandom();
    saved = 32'h0;
    if (v.zero_idx >= 0) begin
      saved = rom_mem[base + v.zero_idx];
      rom_mem[base + v.zero_idx] = 32'h0;
    end
    k = 0; n = 0; cyc = 0; done_cnt = 0; done_cyc = 0; last_acc = 0; stall_cnt = 0;
    err_m = 1'b0; held = 1'b0; pulsed = 1'b0; c_acc = 1'b0;
    h_coef = 32'h0; h_div = 32'h0; h_idx = 6'd0;
    @(negedge clk);
    start_i = 1'b1; chroma_i = v.chroma; coef_valid_i = 1'b0; q_ready_i = 1'b0;
    while (1) begin
      @(negedge clk);
      cyc++;
      start_i = 1'b0; chroma_i = 1'b0;
      if (cyc == 1) check($sformatf("r%0d_fetch_c1", row), {busy_o, coef_ready_o, err_o}, 3'b110);
      if (held) check($sformatf("r%0d_stall_stable", row),
                      {q_valid_o, q_coef_o, q_div_o, q_idx_o}, {1'b1, h_coef, h_div, h_idx});
      held = 1'b0;
      if (done_cnt > 0 && cyc == done_cyc + 1) begin
        check($sformatf("r%0d_idle_after_done", row), {busy_o, done_o}, 2'b00);
        break;
      end
      if (done_o) begin
        done_cnt++; done_cyc = cyc;
        check($sformatf("r%0d_err_at_done", row), err_o, v.exp_err);
        if (v.start_at_done) begin start_i = 1'b1; chroma_i = 1'b1; end
      end
      if (cyc > 3000) begin
        check($sformatf("r%0d_timeout", row), 1'b1, 1'b0);
        break;
      end
      if (v.abort_idx >= 0 && q_valid_o && q_idx_o == 6'(v.abort_idx)) begin
        check($sformatf("r%0d_pairs_before_abort", row), n, v.abort_idx);
        rst_ni = 1'b0; coef_valid_i = 1'b0; q_ready_i = 1'b0;
        @(negedge clk);
        check($sformatf("r%0d_abort_zero", row),
              {coef_ready_o, rom_addr_o, q_valid_o, q_coef_o, q_div_o, q_idx_o, busy_o, done_o, err_o}, '0);
        rst_ni = 1'b1;
        repeat (6) begin
          @(negedge clk);
          if (done_o || busy_o) done_cnt++;
        end
        check($sformatf("r%0d_no_done_after_abort", row), done_cnt, 0);
        return;
      end
      if (v.restart_idx >= 0 && !pulsed && q_valid_o && q_idx_o == 6'(v.restart_idx)) begin
        start_i = 1'b1; chroma_i = ~v.chroma; pulsed = 1'b1;
      end
      // Upstream holds an offered coefficient until it is taken.
      if (k >= 64) vnew = 1'b0;
      else if (coef_valid_i && !c_acc) vnew = 1'b1;
      else vnew = ($urandom_range(99) >= v.gap);
      coef_valid_i = vnew;
      coef_data_i  = vnew ? coefs[k] : $urandom();
      c_acc = vnew && coef_ready_o;
      if (c_acc) k++;
      rnew = ($urandom_range(99) >= v.hold);
      if (q_valid_o && v.stall_idx >= 0 && q_idx_o == 6'(v.stall_idx) && stall_cnt < 5) begin
        rnew = 1'b0; stall_cnt++;
      end
      q_ready_i = rnew;
      if (q_valid_o && rnew) begin
        err_m = err_m | (rom_mem[base + n][30:23] == 8'd0);
        check($sformatf("r%0d_pair%0d", row, n), {q_coef_o, q_div_o, q_idx_o, rom_addr_o},
              {coefs[n], rom_mem[base + n], 6'(n), 13'(base + n)});
        check($sformatf("r%0d_err%0d", row, n), err_o, err_m);
        if (n == 0)  check($sformatf("r%0d_div0", row), q_div_o, v.exp_div0);
        if (n == 63) check($sformatf("r%0d_div63", row), q_div_o, v.exp_div63);
        last_acc = cyc; n++;
      end else if (q_valid_o) begin
        held = 1'b1; h_coef = q_coef_o; h_div = q_div_o; h_idx = q_idx_o;
      end
    end
    coef_valid_i = 1'b0; q_ready_i = 1'b0;
    check($sformatf("r%0d_pair_count", row), n, 64);
    check($sformatf("r%0d_done_once", row), done_cnt, 1);
    check($sformatf("r%0d_done_after_last", row), done_cyc, last_acc + 1);
    if (v.exp_done_cyc > 0) check($sformatf("r%0d_done_cycle", row), done_cyc, v.exp_done_cyc);
    if (v.stall_idx >= 0) check($sformatf("r%0d_stall_len", row), stall_cnt, 5);
    if (v.zero_idx >= 0) rom_mem[base + v.zero_idx] = saved;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      rom_mem[i]      = int_to_fp(luma_tab[i]);
      rom_mem[64 + i] = int_to_fp(chroma_tab[i]);
    end
    //          chr  gap hold stall zero rst abort atdone  done  div0          div63         err
    vecs[0] = '{1'b0, 0,  0,  -1,  -1,  -1,  -1, 1'b0,  257, 32'h41800000, 32'h42C60000, 1'b0};
    vecs[1] = '{1'b1, 0,  0,  -1,  -1,  -1,  -1, 1'b0,  257, 32'h41880000, 32'h42C60000, 1'b0};
    vecs[2] = '{1'b0, 30, 20, 10,  -1,  -1,  -1, 1'b0,   -1, 32'h41800000, 32'h42C60000, 1'b0};
    vecs[3] = '{1'b0, 0,  0,  -1,   5,  -1,  -1, 1'b1,  257, 32'h41800000, 32'h42C60000, 1'b1};
    vecs[4] = '{1'b0, 0,  0,  -1,  -1,  12,  -1, 1'b0,  257, 32'h41800000, 32'h42C60000, 1'b0};
    vecs[5] = '{1'b0, 0,  0,  -1,  -1,  -1,  30, 1'b0,   -1, 32'h41800000, 32'h42C60000, 1'b0};
    vecs[6] = '{1'b1, 40, 30, -1,  -1,  -1,  -1, 1'b0,   -1, 32'h41880000, 32'h42C60000, 1'b0};

    rst_ni = 1'b0; start_i = 1'b0; chroma_i = 1'b0;
    coef_valid_i = 1'b0; coef_data_i = 32'h0; q_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state",
          {coef_ready_o, rom_addr_o, q_valid_o, q_coef_o, q_div_o, q_idx_o, busy_o, done_o, err_o}, '0);
    rst_ni = 1'b1;
    @(negedge clk);
    check("idle_holds", {busy_o, coef_ready_o, q_valid_o}, 3'b000);

    for (int r = 0; r < 7; r++) run_vec(r, vecs[r]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
